rvx_mtimer: RTL
===============

Name: rvx_mtimer

Overview:
- Memory-mapped machine timer that acts as a responder on the rvx data-bus protocol.
- Sources the core's memory_mapped_timer input and irq_timer line; replaces the constant-zero tie-offs used in core-only integrations.
- Sits behind the SoC bus decoder, which gates rrequest/wrequest by base address.
- Holds a 64-bit mtime counter with a programmable prescaler, plus a 64-bit mtimecmp compare register.

Parameters:
- PRESCALER_RESET, 0, reset value of the prescaler register; mtime advances once every (prescaler+1) clocks.
- ENABLE_RESET, 1, reset value of the control enable bit.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- address  input  32  byte address; only address[4:2] decoded.
- rdata  output  32  read data, valid while rresponse=1.
- rrequest  input  1  one-cycle read request.
- rresponse  output  1  read response.
- wdata  input  32  write data.
- wstrobe  input  4  byte enables; wstrobe[i] writes wdata[8i+7:8i].
- wrequest  input  1  one-cycle write request.
- wresponse  output  1  write response.
- memory_mapped_timer  output  64  current mtime value.
- irq_timer  output  1  level interrupt, 1 while mtime >= mtimecmp.

Behaviour:
- Register map (address[4:2]):
  - 0 MTIME_LO
  - 1 MTIME_HI
  - 2 MTIMECMP_LO
  - 3 MTIMECMP_HI
  - 4 CONTROL (bit0 enable; other bits read 0)
  - 5 PRESCALER (32-bit)
  - 6–7 unmapped: read 0, writes ignored but still acknowledged.
- Reset values:
  - mtime=0; mtimecmp=64'hFFFF_FFFF_FFFF_FFFF; prescale counter=0.
  - enable=ENABLE_RESET; prescaler=PRESCALER_RESET.
  - rdata=0, rresponse=0, wresponse=0, irq_timer=0.
- Read: rrequest sampled at edge N → rresponse=1 and rdata=register value at edge N+1, for exactly one cycle. rdata returns to 0 when rresponse=0.
- Write: wrequest at edge N → strobed bytes updated at edge N, wresponse=1 for one cycle at N+1.
- Simultaneous rrequest and wrequest: both serviced, both responses at N+1. Read returns the pre-write value.
- Back-to-back requests on consecutive cycles are each answered; no stall, no buffering beyond one cycle.
- Prescaler:
  - If enable=1, the prescale counter increments each clock.
  - When counter==prescaler, the counter clears to 0 and mtime increments by 1 (64-bit, wraps FFFF_FFFF_FFFF_FFFF→0).
  - prescaler=0 means increment every clock.
  - Writing PRESCALER clears the prescale counter.
  - enable=0 freezes both the counter and mtime.
- Write priority: a bus write to MTIME_LO/HI in the same cycle as an increment takes the written bytes. Unwritten bytes receive the incremented value of that half, with no carry into the written half.
- irq_timer: registered compare of (next mtime >= next mtimecmp), unsigned 64-bit. It therefore rises in the same cycle memory_mapped_timer first satisfies the compare. Writing mtimecmp above mtime deasserts it the cycle after the write.
- memory_mapped_timer: registered mtime, zero extra latency.
- Reset mid-transaction: pending responses are dropped (rresponse/wresponse=0); no write completes.

Decomposition:
- Shared package rvx_mtimer_pkg:
  - register offset constants (MTIME_LO…PRESCALER);
  - CONTROL bit index;
  - MTIMECMP reset constant.
- One sub-module, rvx_mtimer_prescaler: counter + tick output, inputs enable/prescaler/clear.
- Bus decode and registers stay in the top.

Test Plan:
- Reset released, PRESCALER_RESET=0 → memory_mapped_timer reads 0,1,2,3 on successive clocks; irq_timer=0; read MTIMECMP_HI at N → rresponse and rdata=FFFF_FFFF at N+1.
- Write PRESCALER=3 → mtime increments once every 4 clocks; 40 clocks later mtime delta = 10 ±1.
- Write MTIMECMP_HI=0, MTIMECMP_LO=20 with mtime=0 → irq_timer rises the cycle mtime becomes 20. Write MTIMECMP_LO=1000 → irq_timer=0 the next cycle.
- Write MTIME_LO=FFFF_FFFF, MTIME_HI=0 with wstrobe=1111 → next increment reads MTIME_HI=1, MTIME_LO=0. Write MTIME_LO with wstrobe=0001, wdata=AA → only byte 0 changes.
- Simultaneous rrequest+wrequest to PRESCALER (old 5, new 9) → rdata=5, both responses at N+1, subsequent read returns 9. Read address 0x1C → rdata=0, rresponse=1.
- Assert reset the cycle after wrequest → wresponse=0, all registers at reset values; CONTROL enable=0 write freezes memory_mapped_timer for 50 clocks.

Source files
------------

// File: rtl/rvx_mtimer_pkg.sv
// Shared definitions for the rvx machine timer: register offsets, control bit
// positions, reset constants and the byte-strobe merge helper.
package rvx_mtimer_pkg;

  typedef enum logic [2:0] {
    REG_MTIME_LO    = 3'd0,
    REG_MTIME_HI    = 3'd1,
    REG_MTIMECMP_LO = 3'd2,
    REG_MTIMECMP_HI = 3'd3,
    REG_CONTROL     = 3'd4,
    REG_PRESCALER   = 3'd5,
    REG_UNMAPPED_6  = 3'd6,
    REG_UNMAPPED_7  = 3'd7
  } reg_addr_e;

  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam logic [63:0] MTIMECMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF;

  // Byte lanes with their strobe set take the new data; the rest keep old_val.
  function automatic logic [31:0] apply_wstrobe(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strobe);
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strobe[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/rvx_mtimer_if.sv
// rvx data-bus responder port: one-cycle read/write requests answered one
// clock later.
interface rvx_mtimer_if;
  logic [31:0] address;
  logic [31:0] rdata;
  logic        rrequest;
  logic        rresponse;
  logic [31:0] wdata;
  logic [3:0]  wstrobe;
  logic        wrequest;
  logic        wresponse;

  modport master (
    output address, rrequest, wdata, wstrobe, wrequest,
    input  rdata, rresponse, wresponse
  );

  modport slave (
    input  address, rrequest, wdata, wstrobe, wrequest,
    output rdata, rresponse, wresponse
  );
endinterface

// File: rtl/rvx_mtimer_prescaler.sv
// Prescale counter: tick_o pulses once every (prescaler_i+1) enabled clocks.
module rvx_mtimer_prescaler (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_i,
  input  logic [31:0] prescaler_i,
  input  logic        clear_i,
  output logic        tick_o
);

  logic [31:0] count_q;

  assign tick_o = enable_i && (count_q == prescaler_i);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= tick_o ? 32'd0 : count_q + 32'd1;
    end
  end

endmodule

// File: rtl/rvx_mtimer.sv
// Memory-mapped 64-bit machine timer (mtime/mtimecmp) with prescaler, serving
// the rvx data bus and driving the core's timer value and timer interrupt.
module rvx_mtimer
  import rvx_mtimer_pkg::*;
#(
  parameter logic [31:0] PRESCALER_RESET = 32'd0,
  parameter logic        ENABLE_RESET    = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  rvx_mtimer_if.slave  bus,
  output logic [63:0]  memory_mapped_timer,
  output logic         irq_timer
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        enable_q, enable_d;
  logic [31:0] prescaler_q, prescaler_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rresponse_q;
  logic        wresponse_q;
  logic        irq_q, irq_d;
  logic        tick;
  logic        psc_clear;
  reg_addr_e   reg_sel;

  // Only address[4:2] selects a register; the decoder upstream owns the rest.
  logic addr_unused;
  assign addr_unused = ^{bus.address[31:5], bus.address[1:0]};

  assign reg_sel = reg_addr_e'(bus.address[4:2]);

  rvx_mtimer_prescaler u_prescaler (
    .clock       (clock),
    .reset       (reset),
    .enable_i    (enable_q),
    .prescaler_i (prescaler_q),
    .clear_i     (psc_clear),
    .tick_o      (tick)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d  = mtimecmp_q;
    enable_d    = enable_q;
    prescaler_d = prescaler_q;
    psc_clear   = 1'b0;
    if (bus.wrequest) begin
      // Written bytes of mtime override the increment; the others keep it.
      case (reg_sel)
        REG_MTIME_LO:    mtime_d[31:0]     = apply_wstrobe(mtime_d[31:0], bus.wdata, bus.wstrobe);
        REG_MTIME_HI:    mtime_d[63:32]    = apply_wstrobe(mtime_d[63:32], bus.wdata, bus.wstrobe);
        REG_MTIMECMP_LO: mtimecmp_d[31:0]  = apply_wstrobe(mtimecmp_q[31:0], bus.wdata, bus.wstrobe);
        REG_MTIMECMP_HI: mtimecmp_d[63:32] = apply_wstrobe(mtimecmp_q[63:32], bus.wdata, bus.wstrobe);
        REG_CONTROL: begin
          if (bus.wstrobe[0]) enable_d = bus.wdata[CTRL_ENABLE_BIT];
        end
        REG_PRESCALER: begin
          prescaler_d = apply_wstrobe(prescaler_q, bus.wdata, bus.wstrobe);
          psc_clear   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Reads always see the pre-write register contents.
  always_comb begin
    rdata_d = '0;
    if (bus.rrequest) begin
      case (reg_sel)
        REG_MTIME_LO:    rdata_d = mtime_q[31:0];
        REG_MTIME_HI:    rdata_d = mtime_q[63:32];
        REG_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
        REG_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
        REG_CONTROL:     rdata_d[CTRL_ENABLE_BIT] = enable_q;
        REG_PRESCALER:   rdata_d = prescaler_q;
        default:         rdata_d = '0;
      endcase
    end
  end

  assign irq_d = (mtime_d >= mtimecmp_d);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtime_q     <= '0;
      mtimecmp_q  <= MTIMECMP_RESET;
      enable_q    <= ENABLE_RESET;
      prescaler_q <= PRESCALER_RESET;
      rdata_q     <= '0;
      rresponse_q <= 1'b0;
      wresponse_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      enable_q    <= enable_d;
      prescaler_q <= prescaler_d;
      rdata_q     <= rdata_d;
      rresponse_q <= bus.rrequest;
      wresponse_q <= bus.wrequest;
      irq_q       <= irq_d;
    end
  end

  assign bus.rdata           = rdata_q;
  assign bus.rresponse       = rresponse_q;
  assign bus.wresponse       = wresponse_q;
  assign memory_mapped_timer = mtime_q;
  assign irq_timer           = irq_q;

endmodule
